// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: the first asserted request at or after
// last_owner+1, wrapping around the requester ring.
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_owner,
   output logic [NUM_REQ-1:0] pick,
   output logic               valid
);

   always_comb begin
      int          pos;
      logic [IW-1:0] idx;
      pick  = '0;
      valid = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         pos = int'(last_owner) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         idx = IW'(pos);
         if (!valid && req[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Bursting round-robin arbiter that multiplexes NUM_REQ word sources onto a
// single FIFO write port, holding each owner for up to BURST_LEN writes.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic                     write_clk,
   input  logic                     write_resetn,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     full_flag,
   output logic                     write_enable,
   output logic [WIDTH-1:0]         write_data,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BURST_LEN) + 1;
   localparam logic [CW-1:0] BEAT_MAX = CW'(BURST_LEN);

   arb_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] grant_q, grant_nxt, pick;
   logic               pick_vld;
   logic [IW-1:0]      last_owner, last_nxt, owner_idx;
   logic [CW-1:0]      beat, beat_nxt;
   logic               owner_vld;

   rr_priority_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req        (req_valid),
      .last_owner (last_owner),
      .pick       (pick),
      .valid      (pick_vld)
   );

   // grant_q is one-hot (or zero), so OR-reduction gives the owner's view.
   always_comb begin
      owner_idx  = '0;
      write_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            owner_idx  = IW'(i);
            write_data = req_data[i*WIDTH +: WIDTH];
         end
      end
      if (state != GRANT) write_data = '0;
   end

   assign owner_vld    = |(req_valid & grant_q);
   assign write_enable = (state == GRANT) && owner_vld && !full_flag;
   assign req_ready    = write_enable ? grant_q : '0;
   assign grant        = grant_q;
   assign busy         = (state == GRANT);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      last_nxt  = last_owner;
      beat_nxt  = beat;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = GRANT;
               grant_nxt = pick;
               beat_nxt  = '0;
            end
         end
         GRANT: begin
            if (write_enable) beat_nxt = beat + 1'b1;
            // A full FIFO stalls in place; only a dropped request or a
            // completed burst releases the port.
            if (!owner_vld || beat_nxt == BEAT_MAX) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               last_nxt  = owner_idx;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge write_clk or negedge write_resetn) begin
      if (!write_resetn) begin
         state      <= IDLE;
         grant_q    <= '0;
         beat       <= '0;
         last_owner <= IW'(NUM_REQ - 1);
      end else begin
         state      <= state_nxt;
         grant_q    <= grant_nxt;
         beat       <= beat_nxt;
         last_owner <= last_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: default 4x32 instance plus a
// 2-requester BURST_LEN=1 instance.
module tb_fifo_write_arbiter;

   logic         write_clk = 1'b0;
   logic         write_resetn;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic         full_flag;
   logic         write_enable;
   logic [31:0]  write_data;
   logic [3:0]   grant;
   logic         busy;

   logic [1:0]   v1;
   logic [63:0]  d1;
   logic [1:0]   rdy1;
   logic         f1;
   logic         we1;
   logic [31:0]  wd1;
   logic [1:0]   g1;
   logic         b1;

   int checks = 0;
   int errors = 0;

   always #5 write_clk = ~write_clk;

   fifo_write_arbiter u_dut (
      .write_clk(write_clk), .write_resetn(write_resetn),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .full_flag(full_flag), .write_enable(write_enable),
      .write_data(write_data), .grant(grant), .busy(busy)
   );

   fifo_write_arbiter #(.WIDTH(32), .NUM_REQ(2), .BURST_LEN(1)) u_dut1 (
      .write_clk(write_clk), .write_resetn(write_resetn),
      .req_valid(v1), .req_data(d1), .req_ready(rdy1),
      .full_flag(f1), .write_enable(we1),
      .write_data(wd1), .grant(g1), .busy(b1)
   );

   task automatic step();
      @(posedge write_clk);
      #1;
   endtask

   task automatic do_reset();
      write_resetn = 1'b0;
      req_valid = '0; req_data = '0; full_flag = 1'b0;
      v1 = '0; d1 = '0; f1 = 1'b0;
      @(posedge write_clk);
      @(posedge write_clk);
      #1 write_resetn = 1'b1;
   endtask

   // Checks one GRANT write cycle of the main instance.
   task automatic chk_write(input string nm, input logic [3:0] eg, input logic [31:0] ed);
      checks++;
      if (grant !== eg || busy !== 1'b1 || write_enable !== 1'b1 ||
          req_ready !== eg || write_data !== ed) begin
         errors++;
         $display("FAIL %s: grant=%b busy=%b we=%b ready=%b data=%h, expected grant=%b busy=1 we=1 ready=%b data=%h",
                  nm, grant, busy, write_enable, req_ready, write_data, eg, eg, ed);
      end
   endtask

   task automatic chk_idle(input string nm);
      checks++;
      if (grant !== 4'b0 || busy !== 1'b0 || write_enable !== 1'b0 ||
          req_ready !== 4'b0 || write_data !== 32'h0) begin
         errors++;
         $display("FAIL %s: grant=%b busy=%b we=%b ready=%b data=%h, expected all zero",
                  nm, grant, busy, write_enable, req_ready, write_data);
      end
   endtask

   task automatic test_reset();
      write_resetn = 1'b0;
      req_valid = 4'b1111; req_data = {4{32'hDEAD_BEEF}}; full_flag = 1'b0;
      v1 = 2'b11; d1 = {2{32'h1234_5678}}; f1 = 1'b0;
      #3;
      chk_idle("reset_outputs");
      checks++;
      if (g1 !== 2'b0 || we1 !== 1'b0 || rdy1 !== 2'b0 || wd1 !== 32'h0 || b1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs_b1: g=%b we=%b rdy=%b wd=%h busy=%b, expected zeros",
                  g1, we1, rdy1, wd1, b1);
      end
      step();
      chk_idle("reset_held_over_edge");
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0001; req_data = '0; req_data[31:0] = 32'd50;
      #1 chk_idle("single_idle_cycle0");
      for (int b = 0; b < 4; b++) begin
         step();
         chk_write($sformatf("single_beat%0d", b), 4'b0001, 32'd50);
      end
      step();
      chk_idle("single_gap");
      step();
      chk_write("single_regrant", 4'b0001, 32'd50);
      req_valid = '0;
      #1;
      checks++;
      if (write_enable !== 1'b0 || grant !== 4'b0001) begin
         errors++;
         $display("FAIL single_drop: we=%b grant=%b, expected we=0 grant=0001", write_enable, grant);
      end
      step();
      chk_idle("single_after_drop");
   endtask

   task automatic test_rotate();
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0 + i;
      #1;
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < 4; b++) begin
            step();
            chk_write($sformatf("rotate_g%0d_b%0d", g, b), 4'b0001 << (g % 4), 32'hA0 + (g % 4));
         end
         step();
         chk_idle($sformatf("rotate_gap%0d", g));
      end
      req_valid = '0;
   endtask

   task automatic test_full();
      do_reset();
      req_valid = 4'b0001; req_data = '0; req_data[31:0] = 32'd77;
      #1;
      for (int b = 0; b < 2; b++) begin
         step();
         chk_write($sformatf("full_pre%0d", b), 4'b0001, 32'd77);
      end
      for (int s = 0; s < 3; s++) begin
         step();
         full_flag = 1'b1;
         #1;
         checks++;
         if (write_enable !== 1'b0 || req_ready !== 4'b0 || grant !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_stall%0d: we=%b ready=%b grant=%b busy=%b, expected we=0 ready=0000 grant=0001 busy=1",
                     s, write_enable, req_ready, grant, busy);
         end
      end
      step();
      full_flag = 1'b0;
      #1 chk_write("full_post0", 4'b0001, 32'd77);
      step();
      chk_write("full_post1", 4'b0001, 32'd77);
      step();
      chk_idle("full_exit");
      req_valid = '0;
   endtask

   task automatic test_drop();
      do_reset();
      req_valid = 4'b0101; req_data = '0;
      req_data[31:0] = 32'h11; req_data[95:64] = 32'h33;
      #1;
      step();
      chk_write("drop_first", 4'b0001, 32'h11);
      step();
      req_valid = 4'b0100;
      #1;
      checks++;
      if (write_enable !== 1'b0 || req_ready !== 4'b0) begin
         errors++;
         $display("FAIL drop_nonowner: we=%b ready=%b, expected we=0 ready=0000", write_enable, req_ready);
      end
      step();
      chk_idle("drop_idle");
      step();
      chk_write("drop_next_owner", 4'b0100, 32'h33);
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b0010; req_data = '0; req_data[63:32] = 32'h22;
      #1;
      for (int b = 0; b < 2; b++) begin
         step();
         chk_write($sformatf("rmid_pre%0d", b), 4'b0010, 32'h22);
      end
      step();
      write_resetn = 1'b0;
      #1 chk_idle("rmid_async");
      step();
      chk_idle("rmid_held");
      write_resetn = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hC0 + i;
      #1;
      step();
      chk_write("rmid_req0_first", 4'b0001, 32'hC0);
      req_valid = '0;
   endtask

   task automatic test_burst1();
      do_reset();
      v1 = 2'b11; d1 = {32'h22, 32'h11};
      #1;
      for (int s = 1; s <= 5; s++) begin
         logic [1:0] eg;
         step();
         eg = (s % 2 == 0) ? 2'b00 : ((s == 3) ? 2'b10 : 2'b01);
         checks++;
         if (g1 !== eg || we1 !== (eg != 2'b00) || rdy1 !== eg ||
             wd1 !== ((eg == 2'b01) ? 32'h11 : (eg == 2'b10) ? 32'h22 : 32'h0)) begin
            errors++;
            $display("FAIL burst1_cycle%0d: grant=%b we=%b ready=%b data=%h, expected grant=%b",
                     s, g1, we1, rdy1, wd1, eg);
         end
      end
      v1 = '0;
   endtask

   task automatic test_loopback();
      logic [31:0] fifo_q[$];
      logic [31:0] exp_q[$];
      int cnt[4];
      do_reset();
      exp_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200, 32'h201, 32'h202, 32'h203,
                32'h104, 32'h105, 32'h106, 32'h107};
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      req_valid = 4'b0110;
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'(i*256 + cnt[i]);
         #1;
         if (write_enable && !full_flag) fifo_q.push_back(write_data);
         for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
         if (c < 15) step();
      end
      req_valid = '0;
      checks++;
      if (fifo_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL loop_count: got %0d words, expected %0d", fifo_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < fifo_q.size(); k++) begin
         checks++;
         if (fifo_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL loop_word%0d: got %h expected %h", k, fifo_q[k], exp_q[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotate();
      test_full();
      test_drop();
      test_reset_mid();
      test_burst1();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
